// File: rtl/sudoku_session_ctrl.sv
// Sudoku session controller: cursor navigation, row-buffered cell edits
// against a row-wide RAM, sticky win flag and a saturating BCD play timer.
module sudoku_session_ctrl #(
   parameter int GRID_N        = 4,
   parameter int DIGIT_W       = 4,
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int TIME_DIGITS   = 2
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             up,
   input  logic                             down,
   input  logic                             left,
   input  logic                             right,
   input  logic                             wr_req,
   input  logic [DIGIT_W-1:0]               user_num,
   input  logic                             win_in,
   output logic [$clog2(GRID_N)-1:0]        ram_addr,
   output logic                             ram_we,
   output logic [GRID_N*(DIGIT_W+1)-1:0]    ram_wdata,
   input  logic [GRID_N*(DIGIT_W+1)-1:0]    ram_rdata,
   output logic [GRID_N*DIGIT_W-1:0]        row_out,
   output logic [$clog2(GRID_N)-1:0]        cursor_row,
   output logic [$clog2(GRID_N)-1:0]        cursor_col,
   output logic [DIGIT_W-1:0]               cur_num,
   output logic                             wp_ind,
   output logic                             row_valid,
   output logic                             win_latched,
   output logic [4*TIME_DIGITS-1:0]         time_bcd,
   output logic                             time_sat
);

   localparam int AW = $clog2(GRID_N);
   localparam int CW = DIGIT_W + 1;
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [AW-1:0]      LAST_IDX = AW'(GRID_N - 1);
   localparam logic [DIGIT_W-1:0] MAX_NUM  = DIGIT_W'(GRID_N);
   localparam logic [PW-1:0]      LAST_TICK = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD, WRITE} state_t;

   state_t                    state, nextState;
   logic [AW-1:0]             cursorRow, cursorCol;
   logic [GRID_N*CW-1:0]      rowBuf, wrRow;
   logic [DIGIT_W-1:0]        wrNum;
   logic                      wpInd, winLatched;
   logic [PW-1:0]             prescaler;
   logic [4*TIME_DIGITS-1:0]  timeBcd, bcdNext;
   logic                      timeSat, timerRun, tick;
   logic [CW-1:0]             curCell;
   logic                      goUp, goDown, goLeft, goRight, doWr, doRej;

   assign curCell  = rowBuf[cursorCol*CW +: CW];
   assign timerRun = !winLatched && !timeSat;
   assign tick     = timerRun && (prescaler == LAST_TICK);

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= FETCH;
      else     state <= nextState;
   end

   // Next state and request arbitration; only HOLD serves requests, one per cycle
   always_comb begin
      nextState = state;
      goUp = 1'b0; goDown = 1'b0; goLeft = 1'b0; goRight = 1'b0;
      doWr = 1'b0; doRej = 1'b0;
      case (state)
         FETCH: nextState = WAIT;
         WAIT:  nextState = HOLD;
         WRITE: nextState = HOLD;
         HOLD: begin
            if (!winLatched) begin
               if (wr_req) begin
                  if (curCell[CW-1] || (user_num > MAX_NUM)) doRej = 1'b1;
                  else begin
                     doWr      = 1'b1;
                     nextState = WRITE;
                  end
               end else if (up) begin
                  goUp      = 1'b1;
                  nextState = FETCH;
               end else if (down) begin
                  goDown    = 1'b1;
                  nextState = FETCH;
               end else if (left)  goLeft  = 1'b1;
               else if (right)     goRight = 1'b1;
            end
         end
         default: nextState = FETCH;
      endcase
   end

   // Write row: buffer with the cursor cell replaced, protect bit forced clear
   always_comb begin
      wrRow = rowBuf;
      wrRow[cursorCol*CW +: CW] = {1'b0, wrNum};
   end

   // Cursor movement with wrap on both axes
   always_ff @(posedge CLK) begin
      if (RST) begin
         cursorRow <= '0;
         cursorCol <= '0;
      end else begin
         if (goUp)    cursorRow <= (cursorRow == '0) ? LAST_IDX : cursorRow - 1'b1;
         if (goDown)  cursorRow <= (cursorRow == LAST_IDX) ? '0 : cursorRow + 1'b1;
         if (goLeft)  cursorCol <= (cursorCol == '0) ? LAST_IDX : cursorCol - 1'b1;
         if (goRight) cursorCol <= (cursorCol == LAST_IDX) ? '0 : cursorCol + 1'b1;
      end
   end

   // Row buffer: loaded from RAM in WAIT, patched in step with the RAM write
   always_ff @(posedge CLK) begin
      if (RST)                 rowBuf <= '0;
      else if (state == WAIT)  rowBuf <= ram_rdata;
      else if (state == WRITE) rowBuf <= wrRow;
   end

   // Pending digit and write-protect indicator
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrNum <= '0;
         wpInd <= 1'b0;
      end else begin
         if (doWr) wrNum <= user_num;
         if (doRej) wpInd <= 1'b1;
         else if (doWr || goUp || goDown || goLeft || goRight) wpInd <= 1'b0;
      end
   end

   // Sticky win flag
   always_ff @(posedge CLK) begin
      if (RST) winLatched <= 1'b0;
      else if (win_in) winLatched <= 1'b1;
   end

   // BCD increment with ripple carry, and saturation detect at all nines
   always_comb begin
      logic carry;
      bcdNext = timeBcd;
      timeSat = 1'b1;
      carry   = 1'b1;
      for (int i = 0; i < TIME_DIGITS; i++) begin
         if (timeBcd[4*i +: 4] != 4'd9) timeSat = 1'b0;
         if (carry) begin
            if (timeBcd[4*i +: 4] == 4'd9) bcdNext[4*i +: 4] = 4'd0;
            else begin
               bcdNext[4*i +: 4] = timeBcd[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   // Prescaler and seconds counter; both hold once won or saturated
   always_ff @(posedge CLK) begin
      if (RST) begin
         prescaler <= '0;
         timeBcd   <= '0;
      end else if (timerRun) begin
         if (tick) begin
            prescaler <= '0;
            timeBcd   <= bcdNext;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
   end

   // Output mapping; the write strobe is masked by reset to abort a write at once
   always_comb begin
      row_out = '0;
      for (int c = 0; c < GRID_N; c++)
         row_out[c*DIGIT_W +: DIGIT_W] = rowBuf[c*CW +: DIGIT_W];
   end

   assign ram_addr    = cursorRow;
   assign ram_we      = (state == WRITE) && !RST;
   assign ram_wdata   = wrRow;
   assign cursor_row  = cursorRow;
   assign cursor_col  = cursorCol;
   assign cur_num     = curCell[DIGIT_W-1:0];
   assign wp_ind      = wpInd;
   assign row_valid   = (state == HOLD);
   assign win_latched = winLatched;
   assign time_bcd    = timeBcd;
   assign time_sat    = timeSat;

endmodule
